// File: rtl/cache_mem_responder.sv
// Backing-memory responder for the cache mem_* port: single-word read/write
// serviced from an internal word array after a fixed, programmable latency.
module cache_mem_responder #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4096,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] mem_addr_in,
   input  logic [DATA_WIDTH-1:0] mem_wdata_in,
   input  logic                  mem_read_en,
   input  logic                  mem_write_en,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  mem_ready,
   output logic                  mem_err,
   output logic                  busy
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $error("cache_mem_responder: LATENCY must be in 1..255");
   end

   logic [1:0]            state;
   logic [7:0]            cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  write_q;
   logic                  commit;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;

   logic [DATA_WIDTH-1:0] mem_array [DEPTH];

   // Full captured address is range-checked; only the low index bits address the array.
   assign in_range = (32'(addr_q) < DEPTH);
   assign idx      = addr_q[IDX_W-1:0];
   assign commit   = (state == S_WAIT) && (cnt == '0);

   // Storage is deliberately not reset; an async reset forces state to IDLE,
   // so a pending write can never commit once reset has been asserted.
   always_ff @(posedge clk) begin
      if (commit && write_q && in_range) begin
         mem_array[idx] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         mem_data_out <= '0;
         mem_ready    <= 1'b0;
         mem_err      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mem_read_en || mem_write_en) begin
                  addr_q  <= mem_addr_in;
                  wdata_q <= mem_wdata_in;
                  write_q <= mem_write_en;
                  cnt     <= 8'(LATENCY - 1);
                  busy    <= 1'b1;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state     <= S_RESP;
                  mem_ready <= 1'b1;
                  if (!in_range) begin
                     mem_err      <= 1'b1;
                     mem_data_out <= '0;
                  end else if (!write_q) begin
                     mem_data_out <= mem_array[idx];
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            S_RESP: begin
               state     <= S_IDLE;
               mem_ready <= 1'b0;
               mem_err   <= 1'b0;
               busy      <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               mem_ready <= 1'b0;
               mem_err   <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: LATENCY=4 and LATENCY=1 instances,
// directed requests with hand-computed expected data and cycle-exact timing.
module tb_cache_mem_responder;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr4, addr1;
   logic [31:0] wd4, wd1;
   logic        re4, we4, re1, we1;
   logic [31:0] do4, do1;
   logic        rdy4, rdy1, err4, err1, busy4, busy1;

   int checks = 0;
   int passed = 0;
   exp_t q4[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   cache_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4096), .LATENCY(4)) dut4 (
      .clk(clk), .reset(reset), .mem_addr_in(addr4), .mem_wdata_in(wd4),
      .mem_read_en(re4), .mem_write_en(we4), .mem_data_out(do4),
      .mem_ready(rdy4), .mem_err(err4), .busy(busy4)
   );

   cache_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4096), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .mem_addr_in(addr1), .mem_wdata_in(wd1),
      .mem_read_en(re1), .mem_write_en(we1), .mem_data_out(do1),
      .mem_ready(rdy1), .mem_err(err1), .busy(busy1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Response monitors: pop one expectation per mem_ready pulse.
   always @(negedge clk) begin
      if (reset === 1'b1 && rdy4 === 1'b1) begin
         if (q4.size() == 0) begin
            checks++;
            $display("FAIL unexpected_ready4: got ready=1 with data %h, expected no response", do4);
         end else begin
            exp_t e;
            e = q4.pop_front();
            chk("rdata4", do4, e.data);
            chk("err4", 32'(err4), 32'(e.err));
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1 && rdy1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            $display("FAIL unexpected_ready1: got ready=1 with data %h, expected no response", do1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("rdata1", do1, e.data);
            chk("err1", 32'(err1), 32'(e.err));
         end
      end
   end

   // One request; enables dropped right after acceptance. Checks ready/busy each cycle.
   task automatic do_req(input int sel, input logic rd, input logic wr, input logic [15:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err);
      int lat;
      exp_t e;
      lat = (sel != 0) ? 1 : 4;
      e.data = exp_data;
      e.err  = exp_err;
      @(negedge clk);
      if (sel != 0) begin
         addr1 = a; wd1 = wd; re1 = rd; we1 = wr; q1.push_back(e);
      end else begin
         addr4 = a; wd4 = wd; re4 = rd; we4 = wr; q4.push_back(e);
      end
      @(posedge clk); #1;
      re1 = 1'b0; we1 = 1'b0; re4 = 1'b0; we4 = 1'b0;
      for (int j = 1; j <= lat + 1; j++) begin
         @(posedge clk); #1;
         if (sel != 0) begin
            chk("ready1_timing", 32'(rdy1), 32'(j == lat));
            chk("busy1_timing", 32'(busy1), 32'(j <= lat));
         end else begin
            chk("ready4_timing", 32'(rdy4), 32'(j == lat));
            chk("busy4_timing", 32'(busy4), 32'(j <= lat));
         end
      end
   endtask

   initial begin
      exp_t e;
      reset = 1'b0;
      addr4 = '0; wd4 = '0; re4 = 1'b0; we4 = 1'b0;
      addr1 = '0; wd1 = '0; re1 = 1'b0; we1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_data", do4, 32'h0);
      chk("reset_ready", 32'(rdy4), 32'h0);
      chk("reset_err", 32'(err4), 32'h0);
      chk("reset_busy", 32'(busy4), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // 1..2: write then read back, data held afterwards
      do_req(0, 1'b0, 1'b1, 16'h0010, 32'h12345678, 32'h0, 1'b0);
      do_req(0, 1'b1, 1'b0, 16'h0010, 32'h0, 32'h12345678, 1'b0);
      repeat (2) @(posedge clk);
      #1 chk("data_held", do4, 32'h12345678);

      // 3: both enables high -> write
      do_req(0, 1'b1, 1'b1, 16'h0020, 32'hA5A5A5A5, 32'h12345678, 1'b0);
      do_req(0, 1'b1, 1'b0, 16'h0020, 32'h0, 32'hA5A5A5A5, 1'b0);

      // 4: out-of-range access flags error and leaves aliased index 0 intact
      do_req(0, 1'b0, 1'b1, 16'h0000, 32'h11111111, 32'hA5A5A5A5, 1'b0);
      do_req(0, 1'b1, 1'b0, 16'h1000, 32'h0, 32'h0, 1'b1);
      do_req(0, 1'b0, 1'b1, 16'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
      do_req(0, 1'b1, 1'b0, 16'h0000, 32'h0, 32'h11111111, 1'b0);

      // 5: enable held through ready; address change during WAIT is ignored
      @(negedge clk);
      addr4 = 16'h0010; re4 = 1'b1; we4 = 1'b0;
      e.data = 32'h12345678; e.err = 1'b0; q4.push_back(e);
      e.data = 32'hA5A5A5A5; e.err = 1'b0; q4.push_back(e);
      @(posedge clk); #1;
      addr4 = 16'h0020; wd4 = 32'hDEADBEEF;
      for (int j = 1; j <= 11; j++) begin
         @(posedge clk); #1;
         chk("held_en_ready", 32'(rdy4), 32'((j == 4) || (j == 10)));
         chk("held_en_busy", 32'(busy4), 32'((j <= 4) || (j >= 6 && j <= 10)));
         if (j == 6) re4 = 1'b0;
      end

      // 6: reset during WAIT aborts the write
      do_req(0, 1'b0, 1'b1, 16'h0030, 32'h00000001, 32'hA5A5A5A5, 1'b0);
      @(negedge clk);
      addr4 = 16'h0030; wd4 = 32'hDEAD0000; we4 = 1'b1;
      @(posedge clk); #1;
      we4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy4), 32'h0);
      chk("abort_ready", 32'(rdy4), 32'h0);
      chk("abort_data", do4, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      do_req(0, 1'b1, 1'b0, 16'h0030, 32'h0, 32'h00000001, 1'b0);

      // LATENCY=1 instance
      do_req(1, 1'b0, 1'b1, 16'h0005, 32'hCAFEF00D, 32'h0, 1'b0);
      do_req(1, 1'b1, 1'b0, 16'h0005, 32'h0, 32'hCAFEF00D, 1'b0);
      do_req(1, 1'b1, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("q4_drained", 32'(q4.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
